// File: rtl/bin2bcd_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : bin2bcd_seq_if
// Purpose  : start/busy/done handshake bundle for the sequential BCD converter.
//            BCD_BLANK_EN adds the leading-zero blank vector.
// Revision : 1.0 - initial release
// ============================================================================
interface bin2bcd_seq_if #(
    parameter int W      = 8,
    parameter int DIGITS = 3
);
    logic                  start;
    logic [W-1:0]          bin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
`ifdef BCD_BLANK_EN
    logic [DIGITS-1:0]     blank;
`endif

    modport master (
        output start,
        output bin,
        input  busy,
        input  done,
        input  bcd
`ifdef BCD_BLANK_EN
        , input blank
`endif
    );

    modport slave (
        input  start,
        input  bin,
        output busy,
        output done,
        output bcd
`ifdef BCD_BLANK_EN
        , output blank
`endif
    );
endinterface
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module   : bin2bcd_seq
// Purpose  : Double-dabble binary-to-BCD converter, one bit per clock, with a
//            held result. Optional macro BCD_BLANK_EN adds leading-zero blanks.
// Revision : 1.0 - initial release
// ============================================================================
module bin2bcd_seq #(
    parameter int W      = 8,
    parameter int DIGITS = 3
) (
    input  wire logic     clk,
    input  wire logic     reset,
    bin2bcd_seq_if.slave  bus
);
    localparam int C_CNT_W = $clog2(W + 1);
    localparam int C_BCD_W = 4 * DIGITS;

    function automatic bit digits_fit(input int w, input int d);
        longint unsigned p;
        p = 1;
        for (int i = 0; i < d; i++) p = p * 10;
        return p > ((64'd1 << w) - 64'd1);
    endfunction

    if (!digits_fit(W, DIGITS)) begin : g_digits_too_few
        $error("bin2bcd_seq: DIGITS=%0d cannot represent 2^%0d-1", DIGITS, W);
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t               state_q,   state_d;
    logic [W-1:0]         shift_q,   shift_d;
    logic [C_BCD_W-1:0]   scratch_q, scratch_d;
    logic [C_CNT_W-1:0]   count_q,   count_d;
    logic [C_BCD_W-1:0]   bcd_q,     bcd_d;
    logic [C_BCD_W-1:0]   adj;
    logic [C_BCD_W-1:0]   next_scratch;

    // All digits are corrected from their pre-shift values before the shift.
    always_comb begin
        adj = scratch_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end
        end
        next_scratch = {adj[C_BCD_W-2:0], shift_q[W-1]};
    end

`ifdef BCD_BLANK_EN
    logic [DIGITS-1:0]    blank_q, blank_d, next_blank;
    logic                 zero_above;

    always_comb begin
        next_blank = '0;
        zero_above = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            zero_above    = zero_above & (next_scratch[4*i +: 4] == 4'd0);
            next_blank[i] = zero_above;
        end
    end
`endif

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        scratch_d = scratch_q;
        count_d   = count_q;
        bcd_d     = bcd_q;
`ifdef BCD_BLANK_EN
        blank_d   = blank_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    shift_d   = bus.bin;
                    scratch_d = '0;
                    count_d   = C_CNT_W'(W);
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                scratch_d = next_scratch;
                shift_d   = {shift_q[W-2:0], 1'b0};
                count_d   = count_q - C_CNT_W'(1);
                if (count_q == C_CNT_W'(1)) begin
                    bcd_d   = next_scratch;
`ifdef BCD_BLANK_EN
                    blank_d = next_blank;
`endif
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            scratch_q <= '0;
            count_q   <= '0;
            bcd_q     <= '0;
`ifdef BCD_BLANK_EN
            blank_q   <= '0;
`endif
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            scratch_q <= scratch_d;
            count_q   <= count_d;
            bcd_q     <= bcd_d;
`ifdef BCD_BLANK_EN
            blank_q   <= blank_d;
`endif
        end
    end

    assign bus.busy  = (state_q == ST_SHIFT);
    assign bus.done  = (state_q == ST_DONE);
    assign bus.bcd   = bcd_q;
`ifdef BCD_BLANK_EN
    assign bus.blank = blank_q;
`endif
endmodule
`default_nettype wire

// File: tb/tb_bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_bin2bcd_seq
// Purpose  : Self-checking bench for bin2bcd_seq at W=8/DIGITS=3 and
//            W=10/DIGITS=4, against a divide-by-ten decimal reference.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_bin2bcd_seq;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bin2bcd_seq_if #(.W(8),  .DIGITS(3)) if8  ();
    bin2bcd_seq_if #(.W(10), .DIGITS(4)) if10 ();

    bin2bcd_seq #(.W(8),  .DIGITS(3)) u_dut8  (.clk(clk), .reset(reset), .bus(if8.slave));
    bin2bcd_seq #(.W(10), .DIGITS(4)) u_dut10 (.clk(clk), .reset(reset), .bus(if10.slave));

    int total = 0;
    int bad   = 0;

    // Decimal digits by repeated division, packed four bits per digit.
    function automatic logic [63:0] ref_bcd(input longint unsigned v, input int nd);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < nd; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // Digit i (i>=1) is blank when the value is below 10^i.
    function automatic logic [63:0] ref_blank(input longint unsigned v, input int nd);
        logic [63:0] r;
        longint unsigned p;
        r = '0;
        p = 10;
        for (int i = 1; i < nd; i++) begin
            r[i] = (v < p);
            p = p * 10;
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called on a negedge; observes one conversion cycle by cycle.
    task automatic convert(input bit wide, input logic [9:0] v, input string tag);
        int w, nd;
        logic [63:0] prev, exp_bcd, obs_bcd;
        logic obs_busy, obs_done;
        w       = wide ? 10 : 8;
        nd      = wide ? 4 : 3;
        prev    = wide ? 64'(if10.bcd) : 64'(if8.bcd);
        exp_bcd = ref_bcd(64'(v), nd);
        if (wide) begin if10.bin = v; if10.start = 1'b1; end
        else begin if8.bin = v[7:0]; if8.start = 1'b1; end
        @(negedge clk);
        if8.start  = 1'b0;
        if10.start = 1'b0;
        for (int c = 1; c <= w + 3; c++) begin
            obs_busy = wide ? if10.busy : if8.busy;
            obs_done = wide ? if10.done : if8.done;
            obs_bcd  = wide ? 64'(if10.bcd) : 64'(if8.bcd);
            check($sformatf("%s busy c%0d", tag, c), 64'(obs_busy), 64'(c <= w));
            check($sformatf("%s done c%0d", tag, c), 64'(obs_done), 64'(c == w + 1));
            if (c <= w) check($sformatf("%s hold c%0d", tag, c), obs_bcd, prev);
            if (c >= w + 1) begin
                check($sformatf("%s bcd v=%0d", tag, v), obs_bcd, exp_bcd);
`ifdef BCD_BLANK_EN
                check($sformatf("%s blank v=%0d", tag, v),
                      wide ? 64'(if10.blank) : 64'(if8.blank), ref_blank(64'(v), nd));
`endif
            end
            @(negedge clk);
        end
    endtask

    initial begin
        int n, dn;
        reset = 1'b0;
        if8.start  = 1'b0; if8.bin  = '0;
        if10.start = 1'b0; if10.bin = '0;
        repeat (2) @(negedge clk);
        check("rst busy8", 64'(if8.busy), 64'd0);
        check("rst done8", 64'(if8.done), 64'd0);
        check("rst bcd8",  64'(if8.bcd),  64'd0);
        check("rst bcd10", 64'(if10.bcd), 64'd0);
`ifdef BCD_BLANK_EN
        check("rst blank8", 64'(if8.blank), 64'd0);
`endif
        reset = 1'b1;
        @(negedge clk);

        convert(1'b0, 10'd255, "max8");
        convert(1'b0, 10'd0,   "zero");
        convert(1'b0, 10'd9,   "nine");
        convert(1'b0, 10'd100, "hundred");

        // start and bin changes during SHIFT must be ignored
        if8.bin = 8'd37; if8.start = 1'b1;
        @(negedge clk); if8.start = 1'b0;
        repeat (2) @(negedge clk);
        if8.bin = 8'd200; if8.start = 1'b1;
        @(negedge clk); if8.start = 1'b0;
        dn = 0;
        for (int c = 4; c <= 22; c++) begin
            if (if8.done) dn++;
            @(negedge clk);
        end
        check("ignore done count", 64'(dn), 64'd1);
        check("ignore bcd", 64'(if8.bcd), 64'h037);
        check("ignore idle", 64'(if8.busy), 64'd0);

        // continuous start: every input, done spaced W+2 cycles
        if8.bin = 8'd0; if8.start = 1'b1;
        for (int i = 0; i < 256; i++) begin
            n = 0;
            do begin @(negedge clk); n++; end while (!if8.done && n < 30);
            check($sformatf("sweep spacing i=%0d", i), 64'(n), (i == 0) ? 64'd9 : 64'd10);
            check($sformatf("sweep bcd i=%0d", i), 64'(if8.bcd), ref_bcd(64'(i), 3));
            if (i < 255) if8.bin = 8'(i + 1);
            else if8.start = 1'b0;
        end
        @(negedge clk);

        convert(1'b1, 10'd1023, "max10");
        repeat (10) convert(1'b1, 10'($urandom_range(0, 1023)), "rand10");
        repeat (10) convert(1'b0, 10'($urandom_range(0, 255)), "rand8");

        // asynchronous reset in the middle of SHIFT
        if8.bin = 8'd200; if8.start = 1'b1;
        @(negedge clk); if8.start = 1'b0;
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("arst busy", 64'(if8.busy), 64'd0);
        check("arst done", 64'(if8.done), 64'd0);
        check("arst bcd8", 64'(if8.bcd), 64'd0);
        check("arst bcd10", 64'(if10.bcd), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        dn = 0;
        for (int c = 0; c < 12; c++) begin
            if (if8.done || if8.busy) dn++;
            @(negedge clk);
        end
        check("arst no resume", 64'(dn), 64'd0);
        convert(1'b0, 10'd128, "post-reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
